// File: rtl/key_step_clock_gen_pkg.sv
// Shared types and constants for the key step clock generator.
// Holds the pulse FSM state encoding and the key_out bit indices.
package key_step_clock_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  localparam int KEY_CLK = 1;
  localparam int KEY_RST = 0;

endpackage

// File: rtl/key_step_clock_gen_debounce.sv
// Pushbutton debouncer: 2-flop synchronizer plus stability counter.
// Ports: clock, reset (async active-low), raw_n in; level_n, fall_pulse out.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_n,
  output logic level_n,
  output logic fall_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_END = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          fall_q, fall_d;

  // Any agreement with the current level restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    fall_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_END) begin
        level_d = sync_q[1];
        fall_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_n};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      fall_q  <= fall_d;
    end
  end

  assign level_n    = level_q;
  assign fall_pulse = fall_q;

endmodule

// File: rtl/key_step_clock_gen.sv
// Board-side KEY[1:0] source: debounced step/auto clock and stretched reset.
// Ports: clock, reset (async low), btn_step_n, btn_rst_n, sw_run in; key_out, busy, step_count out.
module key_step_clock_gen
  import key_step_clock_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PULSE_CYCLES    = 8,
  parameter int LOW_CYCLES      = 8,
  parameter int AUTO_DIV        = 25000000,
  parameter int RST_HOLD        = 16,
  parameter int CNT_W           = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btn_step_n,
  input  logic             btn_rst_n,
  input  logic             sw_run,
  output logic [1:0]       key_out,
  output logic             busy,
  output logic [CNT_W-1:0] step_count
);

  localparam int PMAX = (PULSE_CYCLES > LOW_CYCLES) ?
                        PULSE_CYCLES : LOW_CYCLES;
  localparam int PW = $clog2(PMAX) + 1;
  localparam int DW = $clog2(AUTO_DIV) + 1;
  localparam int HW = $clog2(RST_HOLD + 1) + 1;

  localparam logic [PW-1:0] HIGH_END = PW'(PULSE_CYCLES - 1);
  localparam logic [PW-1:0] LOW_END  = PW'(LOW_CYCLES - 1);
  localparam logic [DW-1:0] DIV_END  = DW'(AUTO_DIV - 1);
  localparam logic [HW-1:0] HOLD_LD  = HW'(RST_HOLD);

  logic step_fall, step_level_unused;
  logic rst_level_n, rst_fall_unused;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clock      (clock),
    .reset      (reset),
    .raw_n      (btn_step_n),
    .level_n    (step_level_unused),
    .fall_pulse (step_fall)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_db (
    .clock      (clock),
    .reset      (reset),
    .raw_n      (btn_rst_n),
    .level_n    (rst_level_n),
    .fall_pulse (rst_fall_unused)
  );

  state_e           state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [DW-1:0]    div_q, div_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             auto_req, step_req, rst_req;

  // Reset request is combinational on the debounced level so it
  // asserts in the same cycle the level falls.
  always_comb begin
    rst_req  = ~rst_level_n | (hold_q != '0);
    auto_req = sw_run & (div_q == DIV_END);
    step_req = sw_run ? auto_req : step_fall;
    div_d    = '0;
    if (sw_run && !auto_req) div_d = div_q + DW'(1);
    hold_d = '0;
    if (!rst_level_n)        hold_d = HOLD_LD;
    else if (hold_q != '0)   hold_d = hold_q - HW'(1);
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (rst_req) begin
      state_d = ST_IDLE;
      phase_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (step_req) begin
          state_d = ST_HIGH;
          phase_d = '0;
          cnt_d   = cnt_q + CNT_W'(1);
        end
        ST_HIGH: if (phase_q == HIGH_END) begin
          state_d = ST_LOW;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
        ST_LOW: if (phase_q == LOW_END) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
        default: begin
          state_d = ST_IDLE;
          phase_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      div_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    key_out          = '0;
    key_out[KEY_CLK] = (state_q == ST_HIGH);
    key_out[KEY_RST] = rst_req;
  end

  assign busy       = (state_q != ST_IDLE);
  assign step_count = cnt_q;

endmodule

// File: tb/tb_key_step_clock_gen.sv
// Directed bench for key_step_clock_gen with short sim parameters.
// Cycle-exact vector table plus hand sequences for multi-cycle cases.
module tb_key_step_clock_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_step_n;
  logic       btn_rst_n;
  logic       sw_run;
  logic [1:0] key_out;
  logic       busy;
  logic [3:0] step_count;

  key_step_clock_gen #(
    .DEBOUNCE_CYCLES (4),
    .PULSE_CYCLES    (3),
    .LOW_CYCLES      (2),
    .AUTO_DIV        (20),
    .RST_HOLD        (5),
    .CNT_W           (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_step_n (btn_step_n),
    .btn_rst_n  (btn_rst_n),
    .sw_run     (sw_run),
    .key_out    (key_out),
    .busy       (busy),
    .step_count (step_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       s;
    logic       r;
    logic       w;
    logic [1:0] key;
    logic       b;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc_n = 0;
  int   rise_q[$];
  logic prev_k = 1'b0;

  always @(negedge clock) begin
    cyc_n = cyc_n + 1;
    if (key_out[1] && !prev_k) rise_q.push_back(cyc_n);
    prev_k = key_out[1];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic r, input logic w);
    btn_step_n = s;
    btn_rst_n  = r;
    sw_run     = w;
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic s, input logic r, input logic w,
                     input logic [1:0] key, input logic b,
                     input int cnt, input int n);
    vec_t v;
    v.s = s; v.r = r; v.w = w;
    v.key = key; v.b = b; v.cnt = 4'(cnt);
    repeat (n) tbl.push_back(v);
  endtask

  function automatic int pk();
    return {25'd0, key_out, busy, step_count};
  endfunction

  initial begin
    int lat;
    int highs;
    int found;

    // clean press: rises on the 7th edge, 3 high, 2 low
    add(0, 1, 0, 2'b00, 0, 0, 6);
    add(0, 1, 0, 2'b10, 1, 1, 3);
    add(0, 1, 0, 2'b00, 1, 1, 2);
    add(0, 1, 0, 2'b00, 0, 1, 3);
    add(1, 1, 0, 2'b00, 0, 1, 8);
    // reset debounced mid-HIGH, then release and 5-cycle stretch
    add(0, 1, 0, 2'b00, 0, 1, 2);
    add(0, 0, 0, 2'b00, 0, 1, 4);
    add(0, 0, 0, 2'b10, 1, 2, 1);
    add(0, 0, 0, 2'b11, 1, 2, 1);
    add(0, 0, 0, 2'b01, 0, 0, 3);
    add(1, 1, 0, 2'b01, 0, 0, 10);
    add(1, 1, 0, 2'b00, 0, 0, 2);

    reset = 1'b0; btn_step_n = 1'b1;
    btn_rst_n = 1'b1; sw_run = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("in_reset", pk(), 0);
    reset = 1'b1;
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    chk("after_reset", pk(), 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].s, tbl[i].r, tbl[i].w);
      chk($sformatf("vec%0d", i), pk(),
          int'({tbl[i].key, tbl[i].b, tbl[i].cnt}));
    end

    // bounce then stable hold
    rise_q.delete();
    repeat (4) begin
      repeat (3) cyc(0, 1, 0);
      cyc(1, 1, 0);
    end
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(0, 1, 0);
      if (lat == 0 && key_out[1]) lat = i;
    end
    chk("bounce_latency", lat, 7);
    chk("bounce_pulses", rise_q.size(), 1);
    chk("bounce_count", int'(step_count), 1);
    repeat (8) cyc(1, 1, 0);

    // auto-run for 100 cycles with stray presses
    rise_q.delete();
    for (int i = 0; i < 100; i++)
      cyc((i >= 10 && i < 60) ? 1'b0 : 1'b1, 1'b1, 1'b1);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 0);
      if (key_out[1]) highs++;
    end
    chk("auto_pulses", rise_q.size(), 5);
    for (int i = 1; i < rise_q.size(); i++)
      chk($sformatf("auto_space%0d", i),
          rise_q[i] - rise_q[i-1], 20);
    chk("auto_tail_high", highs, 2);
    chk("auto_count", int'(step_count), 6);
    chk("auto_idle", int'(busy), 0);

    // count up to 15, then wrap with one manual step
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      cyc(1, 1, 1);
      if (step_count == 4'd15) found = 1;
    end
    chk("reach15", found, 1);
    repeat (10) cyc(1, 1, 0);
    chk("hold15", int'(step_count), 15);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(0, 1, 0);
      if (lat == 0 && key_out[1]) lat = i;
    end
    chk("wrap_pulse_lat", lat, 7);
    chk("wrap_count", int'(step_count), 0);
    repeat (8) cyc(1, 1, 0);

    // step and reset requests in the same cycle
    rise_q.delete();
    repeat (10) cyc(0, 0, 0);
    chk("simul_pulses", rise_q.size(), 0);
    chk("simul_key", int'(key_out), 1);
    chk("simul_busy", int'(busy), 0);
    repeat (20) cyc(1, 1, 0);
    chk("simul_release", int'(key_out), 0);

    // block reset mid-pulse
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      cyc(0, 1, 0);
      if (key_out[1]) lat = i;
    end
    chk("pre_abort_high", lat, 7);
    #2 reset = 1'b0;
    #1;
    chk("abort_outputs", pk(), 0);
    #10 reset = 1'b1;
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    chk("abort_idle", pk(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
